ptos_serializer: RTL
====================

// Module: ptos_serializer
// PURPOSE
//   Parallel-to-serial transmit stage. It captures a WIDTH-bit word through a
//   load/ready handshake and shifts it out one bit per clk.
//   It sits directly upstream of the serial-to-parallel shift register and drives
//   that register's serial input.
//   ser_valid and frame_start qualify the bit stream. Downstream logic uses them
//   to tell when a complete word has been shifted into the receiver.
// PARAMETERS
//   WIDTH      4   bits per word; legal range >= 2
//   MSB_FIRST  1   1: data_in[WIDTH-1] is sent first; 0: data_in[0] is sent first
// PORTS
//   clk          in   1      rising-edge clock; single clock domain
//   rst          in   1      synchronous reset, active-high
//   load         in   1      request to accept data_in; sampled only while ready=1
//   data_in      in   WIDTH  parallel word; captured on the edge where load&ready
//   ready        out  1      block can accept a word on this cycle
//   ser_out      out  1      serial data bit
//   ser_valid    out  1      ser_out carries a frame bit this cycle
//   frame_start  out  1      first bit of a frame is on ser_out (1-cycle pulse)
//   done         out  1      last bit of a frame is on ser_out (1-cycle pulse)
// BEHAVIOUR
//   - Reset, sampled at a clk edge while rst=1:
//     state=IDLE, shift register=0, bit counter=0, ser_out=0, ser_valid=0,
//     frame_start=0, done=0, ready=1 from the cycle after reset.
//   - States: IDLE and SHIFT.
//   - IDLE: ready=1, ser_valid=0, ser_out=0.
//     If load=1 at an edge: capture data_in, bit counter=0, go to SHIFT.
//   - Latency: the first bit appears on ser_out in the cycle after the capture
//     edge, with ser_valid=1 and frame_start=1.
//   - SHIFT: exactly WIDTH consecutive cycles with ser_valid=1, one bit per cycle,
//     in MSB_FIRST order. The bit counter increments once per cycle.
//   - Last bit (counter == WIDTH-1): done=1 and ready=1.
//     If load=1 on that edge, the new word is captured and its first bit follows
//     with no gap: ser_valid stays 1 and frame_start pulses.
//     Otherwise the block returns to IDLE.
//   - In SHIFT before the last bit: ready=0. load is ignored and data_in is
//     don't-care. No queuing, no error flag.
//   - frame_start and done are both 1 only when WIDTH=1, which is illegal, so
//     they are never high in the same cycle.
//   - All outputs are registered or decoded from registered state only.
//     No combinational path from load or data_in to any output.
//   - Bit counter width is $clog2(WIDTH). The counter must not wrap past WIDTH-1
//     within a frame.
//   - rst mid-frame aborts the frame. On the next cycle all outputs are at their
//     reset values; the partial frame is not completed.
//   - rst and load both 1 at the same edge: rst wins and the word is dropped.
// STRUCTURE
//   - Shared package ptos_pkg:
//     state encoding localparams ST_IDLE=1'b0, ST_SHIFT=1'b1;
//     default word width constant PTOS_WIDTH=4, shared with the receiver
//     shift register.
//   - One sub-module, bit_counter:
//     parameter MAX; inputs clk, rst, clr, en; outputs count, at_max.
//     It also serves the receiver-side frame counter.
//   - Shift register, FSM and output decode stay in ptos_serializer.
// TESTING
//   1. Reset: hold rst=1 for 3 cycles while load=1 and data_in=4'hF
//      -> ser_valid=0, ser_out=0, done=0 throughout; ready=1 after release.
//   2. Single word: WIDTH=4, MSB_FIRST=1, load 4'b1011
//      -> ser_out=1,0,1,1 on cycles +1..+4;
//      frame_start on cycle +1; done on cycle +4; ready=1 again on cycle +4.
//   3. LSB first: MSB_FIRST=0, load 4'b1000
//      -> ser_out=0,0,0,1; done coincides with the final 1.
//   4. Back-to-back: load 4'hA, then load 4'h5 asserted during done
//      -> 8 contiguous valid bits 1,0,1,0,0,1,0,1;
//      frame_start on bits 1 and 5; done on bits 4 and 8.
//   5. Load while busy: load 4'h3, then pulse load with 4'hC on cycle +2
//      -> stream remains 0,0,1,1 and the block returns to IDLE; 4'hC is never sent.
//   6. Reset mid-frame: load 4'hF, assert rst on cycle +2
//      -> ser_valid=0 and ser_out=0 from cycle +3; no done pulse;
//      a subsequent load 4'h9 sends 1,0,0,1 cleanly.
//   - Bench pairs the DUT with the receiver shift register. Checks: after each
//     done, the receiver's parallel output equals the loaded word (MSB_FIRST=1).

Source files
------------

// File: rtl/ptos_pkg.sv
// Shared constants for the parallel-to-serial transmit path.
// Also used by the receive-side shift register.
package ptos_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   localparam int PTOS_WIDTH = 4;

endpackage

// File: rtl/ptos_serializer_bit_counter.sv
// Saturating-at-MAX frame bit counter.
// Shared by the transmit and receive frame logic.
module bit_counter #(
   parameter int MAX = 3
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 clr,
   input  logic                                 en,
   output logic [((MAX < 1) ? 1 : $clog2(MAX + 1))-1:0] count,
   output logic                                 at_max
);

   localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !at_max) begin
         count <= count + CW'(1);
      end
   end

   assign at_max = (count == CW'(MAX));

endmodule

// File: rtl/ptos_serializer.sv
// Parallel-to-serial transmit stage with load/ready handshake.
// Emits WIDTH bits per frame, back-to-back when reloaded on the last bit.
module ptos_serializer
   import ptos_pkg::*;
#(
   parameter int WIDTH     = PTOS_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   output logic             ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   logic             state;
   logic             state_nxt;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    count;
   logic             at_max;
   logic             shifting;
   logic             accept;
   logic             head;

   assign shifting = (state == ST_SHIFT);
   assign accept   = load && ready;
   assign head     = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

   // Counter restarts on every frame boundary, so it never wraps mid-frame.
   bit_counter #(
      .MAX (WIDTH - 1)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (!shifting || at_max),
      .en     (shifting),
      .count  (count),
      .at_max (at_max)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (load) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (at_max) state_nxt = load ? ST_SHIFT : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg <= '0;
      end else if (accept) begin
         sreg <= data_in;
      end else if (shifting) begin
         if (MSB_FIRST) sreg <= {sreg[WIDTH-2:0], 1'b0};
         else           sreg <= {1'b0, sreg[WIDTH-1:1]};
      end
   end

   always_comb begin
      ready       = 1'b0;
      ser_valid   = 1'b0;
      ser_out     = 1'b0;
      frame_start = 1'b0;
      done        = 1'b0;
      unique case (state)
         ST_IDLE: begin
            ready = 1'b1;
         end
         ST_SHIFT: begin
            ready       = at_max;
            ser_valid   = 1'b1;
            ser_out     = head;
            frame_start = (count == '0);
            done        = at_max;
         end
         default: ready = 1'b0;
      endcase
   end

endmodule
